// File: rtl/tomasula_types.sv
// Shared ROB types: op encoding, default depth and the per-entry payload.
// Pure declarations, no timing or flow control of their own.
package tomasula_types;

   localparam int ROB_DEPTH = 8;

   typedef enum logic [2:0] {
      OP_ALU = 3'd0,
      OP_LD  = 3'd1,
      OP_ST  = 3'd2,
      OP_BR  = 3'd3,
      OP_JAL = 3'd4
   } rob_op_t;

   typedef struct packed {
      rob_op_t    op;
      logic [4:0] rd;
      logic [4:0] st_src;
   } rob_entry_t;

endpackage

// File: rtl/rob_commit_ctrl.sv
// Head-of-ROB commit FSM: ALU/JAL/BR retire in the cycle the head is valid; LD/ST hold a
// registered memory request until data_mem_resp, retiring in the resp cycle. kill squashes everything.
module rob_commit_ctrl
   import tomasula_types::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       kill,
   input  logic       head_vld,
   input  rob_op_t    head_op,
   input  logic [4:0] head_rd,
   input  logic       head_mispred,
   input  logic       data_mem_resp,
   output logic       retire,
   output logic       regfile_load,
   output logic       ld_commit_sel,
   output logic       st_commit,
   output logic       ld_br,
   output logic       data_read,
   output logic       data_write
);

   typedef enum logic {S_COMMIT, S_MEM_WAIT} state_t;

   state_t state_q, state_d;
   logic   data_read_q, data_read_d;
   logic   data_write_q, data_write_d;

   always_comb begin
      state_d       = state_q;
      data_read_d   = data_read_q;
      data_write_d  = data_write_q;
      retire        = 1'b0;
      regfile_load  = 1'b0;
      ld_commit_sel = 1'b0;
      st_commit     = 1'b0;
      ld_br         = 1'b0;
      if (rst || kill) begin
         state_d      = S_COMMIT;
         data_read_d  = 1'b0;
         data_write_d = 1'b0;
      end else begin
         case (state_q)
            S_COMMIT: begin
               if (head_vld) begin
                  case (head_op)
                     OP_LD: begin
                        state_d     = S_MEM_WAIT;
                        data_read_d = 1'b1;
                     end
                     OP_ST: begin
                        state_d      = S_MEM_WAIT;
                        data_write_d = 1'b1;
                     end
                     OP_BR: begin
                        retire = 1'b1;
                        ld_br  = head_mispred;
                     end
                     default: begin
                        retire       = 1'b1;
                        regfile_load = (head_rd != 5'd0);
                     end
                  endcase
               end
            end
            S_MEM_WAIT: begin
               if (data_mem_resp) begin
                  retire       = 1'b1;
                  state_d      = S_COMMIT;
                  data_read_d  = 1'b0;
                  data_write_d = 1'b0;
                  if (head_op == OP_LD) begin
                     regfile_load  = (head_rd != 5'd0);
                     ld_commit_sel = 1'b1;
                  end else begin
                     st_commit = 1'b1;
                  end
               end
            end
            default: state_d = S_COMMIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_COMMIT;
         data_read_q  <= 1'b0;
         data_write_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_read_q  <= data_read_d;
         data_write_q <= data_write_d;
      end
   end

   // Reset drops the held request immediately rather than one edge later.
   assign data_read  = data_read_q && !rst;
   assign data_write = data_write_q && !rst;

endmodule

// File: rtl/reorder_buffer_param.sv
// Parametrised in-order ROB: alloc at tail, completion per tag, one retire per cycle at head.
// rob_load while full is dropped; a mispredicted branch retires with ld_br and squashes the ROB next cycle.
module reorder_buffer_param
   import tomasula_types::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rob_load,
   input  logic [2:0]       instr_type,
   input  logic [4:0]       rd,
   input  logic [4:0]       st_src,
   input  logic [DEPTH-1:0] set_rob_valid,
   input  logic [DEPTH-1:0] set_mispredict,
   input  logic             data_mem_resp,
   output logic [TAG_W-1:0] rob_tag,
   output logic [TAG_W-1:0] head_ptr,
   output logic [TAG_W-1:0] curr_ptr,
   output logic             rob_full,
   output logic             rob_empty,
   output logic [DEPTH-1:0] status_rob_valid,
   output logic [4:0]       rd_inflight,
   output logic [4:0]       st_src_head,
   output logic             regfile_load,
   output logic             ld_commit_sel,
   output logic             st_commit,
   output logic             data_read,
   output logic             data_write,
   output logic             ld_br,
   output logic             flush
);

   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   rob_entry_t       entries_q [DEPTH];
   rob_entry_t       entries_d [DEPTH];
   logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [TAG_W:0]   count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d, mispred_q, mispred_d;
   logic [DEPTH-1:0] in_use;
   logic             flush_q, flush_d;
   logic             alloc_ok, retire, ld_br_w, head_vld;

   assign rob_empty = (count_q == '0);
   assign rob_full  = (count_q == FULL_CNT);
   assign alloc_ok  = rob_load && !rob_full && !flush_q;
   assign head_vld  = !rob_empty && valid_q[head_q];

   // An entry is live when its distance from head is below the occupancy count.
   always_comb begin
      in_use = '0;
      for (int i = 0; i < DEPTH; i++) begin
         in_use[i] = ({1'b0, TAG_W'(i) - head_q} < count_q);
      end
   end

   always_comb begin
      entries_d = entries_q;
      valid_d   = valid_q;
      mispred_d = mispred_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      flush_d   = ld_br_w;
      if (flush_q) begin
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
         valid_d   = '0;
         mispred_d = '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (set_rob_valid[i] && in_use[i]) begin
               valid_d[i]   = 1'b1;
               mispred_d[i] = set_mispredict[i];
            end
         end
         if (alloc_ok) begin
            entries_d[tail_q] = '{op: rob_op_t'(instr_type), rd: rd, st_src: st_src};
            valid_d[tail_q]   = 1'b0;
            mispred_d[tail_q] = 1'b0;
            tail_d            = tail_q + 1'b1;
         end
         if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
         end
         case ({alloc_ok, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         valid_q   <= '0;
         mispred_q <= '0;
         flush_q   <= 1'b0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         mispred_q <= mispred_d;
         flush_q   <= flush_d;
      end
   end

   rob_commit_ctrl u_commit (
      .clk           (clk),
      .rst           (rst),
      .kill          (flush_q),
      .head_vld      (head_vld),
      .head_op       (entries_q[head_q].op),
      .head_rd       (entries_q[head_q].rd),
      .head_mispred  (mispred_q[head_q]),
      .data_mem_resp (data_mem_resp),
      .retire        (retire),
      .regfile_load  (regfile_load),
      .ld_commit_sel (ld_commit_sel),
      .st_commit     (st_commit),
      .ld_br         (ld_br_w),
      .data_read     (data_read),
      .data_write    (data_write)
   );

   assign rob_tag          = tail_q;
   assign curr_ptr         = tail_q;
   assign head_ptr         = head_q;
   assign status_rob_valid = valid_q;
   assign rd_inflight      = entries_q[head_q].rd;
   assign st_src_head      = entries_q[head_q].st_src;
   assign ld_br            = ld_br_w;
   assign flush            = flush_q;

endmodule
